// File: rtl/ky32_pkg.sv
// ky32_pkg: kythera32 load/store funct3 codes and the data-memory controller state type.
package ky32_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } ky32_dmem_state_t;

endpackage

// File: rtl/ky32_dmem_ram.sv
// ky32_dmem_ram: single-port synchronous data RAM with byte enables and 1-cycle read latency.
module ky32_dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ky32_dmem_ctrl.sv
// ky32_dmem_ctrl: kythera32 data-memory controller with lane steering, wait states and error responses.
// Define KY32_DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of forcing alignment.
module ky32_dmem_ctrl
    import ky32_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    ky32_dmem_state_t state, state_nx;
    logic          we_q, err_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q, ram_wdata, ram_rdata, ld_data;
    logic [3:0]    cnt, be;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          hs, f3_ok, oob, misalign, req_err, ram_en;

    assign req_ready = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign hs        = req_valid && req_ready;

    assign f3_ok = req_we ? req_funct3 inside {F3_SB, F3_SH, F3_SW}
                          : req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    assign oob   = |req_addr[31:AW+2];
`ifdef KY32_DMEM_MISALIGN_TRAP_EN
    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign req_err = oob || !f3_ok || misalign;

    // Sub-size offset bits are ignored for wider accesses, which forces alignment when traps are off.
    assign ram_en    = state == ST_ACCESS && cnt == 4'd0;
    assign be        = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                       f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign ram_wdata = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                       f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign ld_byte   = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half   = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    assign ld_data   = f3_q == F3_LB  ? {{24{ld_byte[7]}}, ld_byte} :
                       f3_q == F3_LBU ? {24'd0, ld_byte} :
                       f3_q == F3_LH  ? {{16{ld_half[15]}}, ld_half} :
                       f3_q == F3_LHU ? {16'd0, ld_half} : ram_rdata;

    ky32_dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (we_q),
        .be   (be),
        .addr (addr_q[AW+1:2]),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = hs ? (req_err ? ST_RESP : ST_ACCESS) : ST_IDLE;
            ST_ACCESS: state_nx = cnt == 4'd0 ? ST_RESP : ST_ACCESS;
            ST_RESP:   state_nx = rsp_valid && rsp_ready ? ST_IDLE : ST_RESP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // The first RESP cycle waits out the RAM read latency before the response is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs) begin
                we_q    <= req_we;
                err_q   <= req_err;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                cnt     <= 4'(WAIT_STATES);
            end else if (state == ST_ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ST_RESP && !rsp_valid) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_q;
                rsp_rdata <= err_q || we_q ? 32'd0 : ld_data;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
